// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared state encoding and default geometry for the sprite line renderer
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOAD,
        FETCH,
        WAIT_HSTART,
        DRAW
    } state_t;

    localparam int DEF_W = 16;
    localparam int DEF_H = 16;

endpackage

// File: rtl/sprite_line_renderer_if.sv
// rtl/sprite_line_renderer_if.sv - timing/ROM/pixel signal bundle between sync logic and one sprite renderer
interface sprite_line_renderer_if
    import sprite_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int H  = DEF_H,
    parameter int AW = $clog2(H)
);

    logic          vstart;
    logic          load;
    logic          hstart;
    logic          hflip;
    logic          vflip;
    logic          scale2;
    logic [AW-1:0] rom_addr;
    logic [W-1:0]  rom_bits;
    logic          gfx;
    logic          in_progress;
    logic          done;

    modport master (
        output vstart, load, hstart, hflip, vflip, scale2, rom_bits,
        input  rom_addr, gfx, in_progress, done
    );

    modport slave (
        input  vstart, load, hstart, hflip, vflip, scale2, rom_bits,
        output rom_addr, gfx, in_progress, done
    );

endinterface

// File: rtl/sprite_line_renderer.sv
// rtl/sprite_line_renderer.sv - 1-bpp W x H scanline sprite engine with flips; SPRITE_SCALE_EN adds 2x scaling
module sprite_line_renderer
    import sprite_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int H  = DEF_H,
    parameter int AW = $clog2(H)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sprite_line_renderer_if.slave   bus
);

    localparam int PW = $clog2(W);
`ifdef SPRITE_SCALE_EN
    localparam int XW = PW + 2;
`else
    localparam int XW = PW + 1;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] row_q;
    logic [XW-1:0] x_q;
    logic [W-1:0]  line_q;
    logic          hflip_q, vflip_q;
    logic          scale_q, sub_q;
    logic [AW-1:0] rom_addr_q;
    logic          gfx_q, done_q;

    logic [XW-1:0] x_last;
    logic [PW-1:0] px, pix_idx;
    logic          x_end, frame_end;

`ifdef SPRITE_SCALE_EN
    assign x_last = scale_q ? XW'(2 * W - 1) : XW'(W - 1);
`else
    logic unused_scale;
    assign unused_scale = bus.scale2;
    assign scale_q      = 1'b0;
    assign sub_q        = 1'b0;
    assign x_last       = XW'(W - 1);
`endif

    // Scaled rows repeat each pixel twice, so the pixel index drops the x LSB.
    assign px        = scale_q ? x_q[PW:1] : x_q[PW-1:0];
    assign pix_idx   = hflip_q ? ~px : px;
    assign x_end     = (x_q == x_last);
    assign frame_end = (row_q == AW'(H - 1)) && (!scale_q || sub_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (bus.vstart) state_d = WAIT_LOAD;
            WAIT_LOAD:   if (bus.load)   state_d = FETCH;
            FETCH:                       state_d = WAIT_HSTART;
            WAIT_HSTART: if (bus.hstart) state_d = DRAW;
            DRAW:        if (x_end)      state_d = frame_end ? IDLE : WAIT_LOAD;
            default:                     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q      <= '0;
            x_q        <= '0;
            line_q     <= '0;
            hflip_q    <= 1'b0;
            vflip_q    <= 1'b0;
            rom_addr_q <= '0;
            gfx_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            gfx_q  <= (state_q == DRAW) ? line_q[pix_idx] : 1'b0;
            done_q <= (state_q == DRAW) && x_end && frame_end;
            unique case (state_q)
                IDLE: begin
                    row_q <= '0;
                    if (bus.vstart) begin
                        hflip_q <= bus.hflip;
                        vflip_q <= bus.vflip;
                    end
                end
                WAIT_LOAD: begin
                    x_q <= '0;
                    if (bus.load) rom_addr_q <= vflip_q ? ~row_q : row_q;
                end
                FETCH: line_q <= bus.rom_bits;
                DRAW: begin
                    x_q <= x_q + XW'(1);
                    if (x_end) begin
                        x_q <= '0;
                        if (frame_end)                row_q <= '0;
                        else if (!scale_q || sub_q)   row_q <= row_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPRITE_SCALE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scale_q <= 1'b0;
            sub_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            sub_q <= 1'b0;
            if (bus.vstart) scale_q <= bus.scale2;
        end else if (state_q == DRAW && x_end) begin
            sub_q <= scale_q && !sub_q;
        end
    end
`endif

    assign bus.rom_addr    = rom_addr_q;
    assign bus.gfx         = gfx_q;
    assign bus.done        = done_q;
    assign bus.in_progress = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb/tb_sprite_line_renderer.sv - directed and randomized frames checked against a bitmap-level reference model
module tb_sprite_line_renderer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = $clog2(H);
    localparam int PW = $clog2(W);
`ifdef SPRITE_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [W-1:0] rom [H];

    sprite_line_renderer_if #(.W(W), .H(H)) bus ();

    sprite_line_renderer #(.W(W), .H(H)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_bits = rom[bus.rom_addr];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel p of on-screen line k, derived straight from the bitmap and flip/scale rules.
    function automatic int exp_pix(input int k, input int p, input int hf, input int vf, input int s);
        int r, col;
        logic [AW-1:0] ra;
        logic [PW-1:0] ca;
        logic [W-1:0]  row_v;
        r   = vf ? (H - 1 - (k >> s)) : (k >> s);
        col = hf ? (W - 1 - (p >> s)) : (p >> s);
        ra  = r[AW-1:0];
        ca  = col[PW-1:0];
        row_v = rom[ra];
        return int'(row_v[ca]);
    endfunction

    task automatic run_line(input int k, input int last, input int hf, input int vf, input int s,
                            input int early, input int abort_px);
        int npx, rr, fin;
        npx = W << s;
        rr  = vf ? (H - 1 - (k >> s)) : (k >> s);
        bus.load = 1'b1;
        tick;
        bus.load = 1'b0;
        if (early != 0) bus.hstart = 1'b1;
        check("rom_addr", 32'(bus.rom_addr), rr);
        tick;
        bus.hstart = 1'b0;
        if (early != 0) begin
            repeat (3) begin
                check("gfx_wait_hstart", 32'(bus.gfx), 0);
                tick;
            end
        end
        bus.hstart = 1'b1;
        tick;
        bus.hstart = 1'b0;
        check("gfx_pre_draw", 32'(bus.gfx), 0);
        tick;
        for (int p = 0; p < npx; p++) begin
            fin = (last != 0 && p == npx - 1) ? 1 : 0;
            check("gfx_pixel", 32'(bus.gfx), exp_pix(k, p, hf, vf, s));
            check("done", 32'(bus.done), fin);
            check("in_progress_draw", 32'(bus.in_progress), 1 - fin);
            if (p == abort_px) begin
                reset_n = 1'b0;
                #1;
                check("gfx_reset", 32'(bus.gfx), 0);
                check("in_progress_reset", 32'(bus.in_progress), 0);
                check("done_reset", 32'(bus.done), 0);
                return;
            end
            tick;
        end
        check("gfx_after_line", 32'(bus.gfx), 0);
        check("done_after_line", 32'(bus.done), 0);
    endtask

    task automatic run_frame(input int hf, input int vf, input int sc, input int early_line,
                             input int abort_line, input int abort_px);
        int s, n;
        s = (SCALE_EN && sc != 0) ? 1 : 0;
        n = H << s;
        check("in_progress_idle", 32'(bus.in_progress), 0);
        bus.hflip  = hf[0];
        bus.vflip  = vf[0];
        bus.scale2 = sc[0];
        bus.vstart = 1'b1;
        tick;
        bus.vstart = 1'b0;
        check("in_progress_start", 32'(bus.in_progress), 1);
        for (int k = 0; k < n; k++) begin
            run_line(k, (k == n - 1) ? 1 : 0, hf, vf, s, (k == early_line) ? 1 : 0,
                     (k == abort_line) ? abort_px : -1);
            if (k == abort_line) return;
            if (k != n - 1) begin
                bus.hflip  = 1'($urandom);
                bus.vflip  = 1'($urandom);
                bus.scale2 = 1'($urandom);
                bus.vstart = 1'($urandom);
                repeat ($urandom_range(0, 2)) tick;
                bus.vstart = 1'b0;
            end
        end
        check("in_progress_end", 32'(bus.in_progress), 0);
        tick;
        check("done_single", 32'(bus.done), 0);
    endtask

    initial begin
        bus.vstart = 1'b0;
        bus.load   = 1'b0;
        bus.hstart = 1'b0;
        bus.hflip  = 1'b0;
        bus.vflip  = 1'b0;
        bus.scale2 = 1'b0;
        rom[0] = 8'h01;
        rom[1] = 8'h02;
        rom[2] = 8'h04;
        rom[3] = 8'h08;
        tick;
        tick;
        check("reset_gfx", 32'(bus.gfx), 0);
        check("reset_rom_addr", 32'(bus.rom_addr), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_in_progress", 32'(bus.in_progress), 0);
        reset_n = 1'b1;
        tick;

        run_frame(0, 0, 0, -1, -1, -1);
        run_frame(1, 0, 0, -1, -1, -1);
        run_frame(0, 1, 0, -1, -1, -1);
        run_frame(0, 0, 1, -1, -1, -1);
        run_frame(0, 0, 0, 1, -1, -1);

        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < H; r++) rom[r] = W'($urandom);
            run_frame(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, H)), -1, -1);
        end

        rom[0] = 8'h01;
        rom[1] = 8'h02;
        rom[2] = 8'hFF;
        rom[3] = 8'h08;
        run_frame(0, 0, 0, -1, 2, 3);
        tick;
        check("reset_mid_gfx", 32'(bus.gfx), 0);
        check("reset_mid_rom_addr", 32'(bus.rom_addr), 0);
        reset_n = 1'b1;
        tick;
        run_frame(0, 0, 0, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
